// File: rtl/serial_cmd_port.sv
// serial_cmd_port: UART command/response port for the logic sniffer core.
//
// RX side receives 8N1 bytes and assembles SUMP commands: 1-byte short
// commands (opcode[7]=0) and 5-byte long commands (opcode[7]=1, opdata LSB
// first). Each finished command appears on cmd with a one-cycle execute.
// TX side serialises byte-masked response words through a byte FIFO and
// answers the ID (0x02) and dataIn (0x06) queries on its own.
//
// Ports:
//   clock       system clock
//   extReset_n  synchronous active-low reset
//   rx          asynchronous serial input (two-flop synchronised here)
//   tx          serial output, idle high
//   dataIn      live probe value returned by query 0x06
//   send        pulse: load send_data/send_valid into the TX loader
//   send_data   response word, byte 0 = [7:0]
//   send_valid  per-byte enable mask
//   send_ready  loader idle; send is only accepted while high
//   cmd         {opdata[31:0], opcode[7:0]} of the last command
//   execute     one-cycle pulse when cmd is updated
//   busy        loader active, FIFO non-empty or shifter active
//   frame_err   one-cycle pulse on a bad stop bit
module serial_cmd_port #(
    parameter int FREQ         = 100000000,
    parameter int RATE         = 115200,
    parameter int DATA_BYTES   = 4,
    parameter int TXFIFO_DEPTH = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                    clock,
    input  logic                    extReset_n,
    input  logic                    rx,
    output logic                    tx,
    input  logic [31:0]             dataIn,
    input  logic                    send,
    input  logic [8*DATA_BYTES-1:0] send_data,
    input  logic [DATA_BYTES-1:0]   send_valid,
    output logic                    send_ready,
    output logic [39:0]             cmd,
    output logic                    execute,
    output logic                    busy,
    output logic                    frame_err
);

    localparam int DIV     = FREQ / RATE;
    localparam int CW      = $clog2(DIV + 1);
    localparam int TO_CLKS = TIMEOUT_BITS * DIV;
    localparam int TW      = $clog2(TO_CLKS + 1);
    // Staging holds at least 4 bytes so the built-in 32-bit query answers fit
    localparam int SB      = (DATA_BYTES > 4) ? DATA_BYTES : 4;
    localparam int SW      = $clog2(SB);
    localparam int AW      = $clog2(TXFIFO_DEPTH);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TO_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {LD_IDLE, LD_PUSH} ld_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t          rx_state_q, rx_state_d;
    logic [2:0]         rx_sync_q, rx_sync_d;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [7:0]         opcode_q, opcode_d;
    logic [31:0]        opdata_q, opdata_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic [39:0]        cmd_q, cmd_d;
    logic               execute_q, execute_d;
    logic               frame_err_q, frame_err_d;
    logic               id_pend_q, id_pend_d;
    logic               din_pend_q, din_pend_d;
    logic [31:0]        din_cap_q, din_cap_d;
    ld_state_t          ld_state_q, ld_state_d;
    logic [8*SB-1:0]    stage_data_q, stage_data_d;
    logic [SB-1:0]      stage_mask_q, stage_mask_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [7:0]         fifo_mem_q [TXFIFO_DEPTH];
    tx_state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [3:0]         tx_bit_q, tx_bit_d;
    logic [9:0]         tx_shift_q, tx_shift_d;

    logic               rx_synced, rx_prev, byte_done;
    logic               fifo_empty, fifo_full, push, pop;
    logic [7:0]         push_byte, fifo_head;
    logic [SW-1:0]      sel;
    logic [SB-1:0]      remaining;

    assign rx_synced  = rx_sync_q[1];
    assign rx_prev    = rx_sync_q[2];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    assign tx         = (tx_state_q == TX_SEND) ? tx_shift_q[0] : 1'b1;
    assign cmd        = cmd_q;
    assign execute    = execute_q;
    assign frame_err  = frame_err_q;
    // A pending query will claim the loader next, so a send would be lost
    assign send_ready = (ld_state_q == LD_IDLE) && !id_pend_q && !din_pend_q;
    assign busy       = (ld_state_q == LD_PUSH) || id_pend_q || din_pend_q ||
                        !fifo_empty || (tx_state_q == TX_SEND);

    // RX receiver and command assembler
    always_comb begin
        rx_sync_d   = {rx_sync_q[1:0], rx};
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        byte_idx_d  = byte_idx_q;
        opcode_d    = opcode_q;
        opdata_d    = opdata_q;
        to_cnt_d    = to_cnt_q;
        cmd_d       = cmd_q;
        execute_d   = 1'b0;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev && !rx_synced) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid start bit: a high line means the edge was a glitch
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_synced ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_synced, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_synced) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // Partial long commands expire after a quiet line of TIMEOUT_BITS bits
        if (rx_state_q != RX_IDLE || byte_idx_q == 3'd0) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_M1) begin
            to_cnt_d   = '0;
            byte_idx_d = 3'd0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (frame_err_d) begin
            byte_idx_d = 3'd0;
        end

        // Operand bytes shift in from the top so byte 1 ends up in [7:0]
        if (byte_done) begin
            if (byte_idx_q == 3'd0) begin
                if (!rx_shift_q[7]) begin
                    cmd_d     = {32'h0, rx_shift_q};
                    execute_d = 1'b1;
                end else begin
                    opcode_d   = rx_shift_q;
                    byte_idx_d = 3'd1;
                end
            end else begin
                opdata_d = {rx_shift_q, opdata_q[31:8]};
                if (byte_idx_q == 3'd4) begin
                    cmd_d      = {rx_shift_q, opdata_q[31:8], opcode_q};
                    execute_d  = 1'b1;
                    byte_idx_d = 3'd0;
                end else begin
                    byte_idx_d = byte_idx_q + 3'd1;
                end
            end
        end
    end

    // TX shifter: chains straight into the next FIFO byte after a stop bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop        = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = {1'b1, fifo_head, 1'b0};
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            tx_shift_d = {1'b1, fifo_head, 1'b0};
                            tx_bit_d   = '0;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Loader: stages a query answer or send word, then pushes its valid bytes
    always_comb begin
        ld_state_d   = ld_state_q;
        stage_data_d = stage_data_q;
        stage_mask_d = stage_mask_q;
        id_pend_d    = id_pend_q;
        din_pend_d   = din_pend_q;
        din_cap_d    = din_cap_q;
        push         = 1'b0;

        sel = '0;
        for (int i = SB - 1; i >= 0; i--) begin
            if (stage_mask_q[i]) begin
                sel = SW'(i);
            end
        end
        push_byte      = stage_data_q[8*sel +: 8];
        remaining      = stage_mask_q;
        remaining[sel] = 1'b0;

        case (ld_state_q)
            LD_IDLE: begin
                if (id_pend_q) begin
                    stage_data_d        = '0;
                    stage_data_d[31:0]  = 32'h534C4131;
                    stage_mask_d        = '0;
                    stage_mask_d[3:0]   = 4'hF;
                    id_pend_d           = 1'b0;
                    ld_state_d          = LD_PUSH;
                end else if (din_pend_q) begin
                    stage_data_d        = '0;
                    stage_data_d[31:0]  = din_cap_q;
                    stage_mask_d        = '0;
                    stage_mask_d[3:0]   = 4'hF;
                    din_pend_d          = 1'b0;
                    ld_state_d          = LD_PUSH;
                end else if (send) begin
                    stage_data_d                   = '0;
                    stage_data_d[8*DATA_BYTES-1:0] = send_data;
                    stage_mask_d                   = '0;
                    stage_mask_d[DATA_BYTES-1:0]   = send_valid;
                    ld_state_d                     = LD_PUSH;
                end
            end
            LD_PUSH: begin
                if (stage_mask_q == '0) begin
                    ld_state_d = LD_IDLE;
                end else if (!fifo_full || pop) begin
                    push         = 1'b1;
                    stage_mask_d = remaining;
                    if (remaining == '0) begin
                        ld_state_d = LD_IDLE;
                    end
                end
            end
            default: ld_state_d = LD_IDLE;
        endcase

        // Set after the clears so a query arriving while another is loaded stays pending
        if (execute_q && cmd_q[7:0] == 8'h02) begin
            id_pend_d = 1'b1;
        end
        if (execute_q && cmd_q[7:0] == 8'h06) begin
            din_pend_d = 1'b1;
            din_cap_d  = dataIn;
        end

        wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    end

    // State registers
    always_ff @(posedge clock) begin
        if (!extReset_n) begin
            rx_state_q   <= RX_IDLE;
            rx_sync_q    <= 3'b111;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_idx_q   <= '0;
            opcode_q     <= '0;
            opdata_q     <= '0;
            to_cnt_q     <= '0;
            cmd_q        <= '0;
            execute_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            id_pend_q    <= 1'b0;
            din_pend_q   <= 1'b0;
            din_cap_q    <= '0;
            ld_state_q   <= LD_IDLE;
            stage_data_q <= '0;
            stage_mask_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '1;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_sync_q    <= rx_sync_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_idx_q   <= byte_idx_d;
            opcode_q     <= opcode_d;
            opdata_q     <= opdata_d;
            to_cnt_q     <= to_cnt_d;
            cmd_q        <= cmd_d;
            execute_q    <= execute_d;
            frame_err_q  <= frame_err_d;
            id_pend_q    <= id_pend_d;
            din_pend_q   <= din_pend_d;
            din_cap_q    <= din_cap_d;
            ld_state_q   <= ld_state_d;
            stage_data_q <= stage_data_d;
            stage_mask_q <= stage_mask_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
        end
    end

endmodule
